div_sequencer: RTL and testbench

- Multi-cycle 64-bit integer divider controller for the execute stage.
- Implements RISC-V DIV/DIVU/REM/REMU semantics.
- Sequences a restoring shift-subtract loop, one quotient bit per cycle.
- Operand absolute values and result sign fixes use the existing two's-complement `opposite` negation block; the subtractor uses `full_adder`.

---
 rtl/div_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_div_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign handling around an unsigned shift-subtract core.

module full_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
            assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
        end
    endgenerate

    assign cout_o = carry[WIDTH];
endmodule

module opposite #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] neg_o
);
    assign neg_o = ~a_i + WIDTH'(1);
endmodule

module div_sequencer #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                is_signed,
    input  logic [WORDSIZE-1:0] dividend,
    input  logic [WORDSIZE-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [WORDSIZE-1:0] quotient,
    output logic [WORDSIZE-1:0] remainder,
    output logic                div_zero
);
    localparam int CW = $clog2(WORDSIZE + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [WORDSIZE-1:0] MIN_NEG = {1'b1, {(WORDSIZE - 1){1'b0}}};

    logic [2:0]          state_q, state_d;
    logic                signed_q, signed_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [WORDSIZE-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient as it shifts
    logic [WORDSIZE-1:0] dvsr_q, dvsr_d;
    logic [WORDSIZE-1:0] rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WORDSIZE-1:0] quot_q, quot_d;
    logic [WORDSIZE-1:0] rmd_q, rmd_d;
    logic                dz_q, dz_d;

    logic [WORDSIZE-1:0] neg_dvd;
    logic [WORDSIZE-1:0] neg_dvsr;
    logic [WORDSIZE-1:0] neg_rem;
    logic [WORDSIZE-1:0] rem_sh;
    logic [WORDSIZE-1:0] trial;
    logic                trial_carry;
    logic                trial_ge;

    opposite #(.WIDTH(WORDSIZE)) u_neg_dvd  (.a_i(dvd_q),  .neg_o(neg_dvd));
    opposite #(.WIDTH(WORDSIZE)) u_neg_dvsr (.a_i(dvsr_q), .neg_o(neg_dvsr));
    opposite #(.WIDTH(WORDSIZE)) u_neg_rem  (.a_i(rem_q),  .neg_o(neg_rem));

    // The bit shifted out of rem_q is the (WORDSIZE+1)-th bit of the shifted
    // remainder; together with the adder carry it gives the unsigned compare.
    assign rem_sh = {rem_q[WORDSIZE-2:0], dvd_q[WORDSIZE-1]};

    full_adder #(.WIDTH(WORDSIZE)) u_sub (
        .a_i    (rem_sh),
        .b_i    (neg_dvsr),
        .cin_i  (1'b0),
        .sum_o  (trial),
        .cout_o (trial_carry)
    );

    assign trial_ge = rem_q[WORDSIZE-1] | trial_carry;

    always_comb begin
        state_d  = state_q;
        signed_d = signed_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dvd_d    = dvd_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rmd_d    = rmd_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    signed_d = is_signed;
                    qneg_d   = is_signed & (dividend[WORDSIZE-1] ^ divisor[WORDSIZE-1]);
                    rneg_d   = is_signed & dividend[WORDSIZE-1];
                    dvd_d    = dividend;
                    dvsr_d   = divisor;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rmd_d   = dividend;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (is_signed && dividend == MIN_NEG && divisor == '1) begin
                        quot_d  = dividend;
                        rmd_d   = '0;
                        dz_d    = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PREP;
                    end
                end
            end
            S_PREP: begin
                if (signed_q && dvd_q[WORDSIZE-1]) begin
                    dvd_d = neg_dvd;
                end
                if (signed_q && dvsr_q[WORDSIZE-1]) begin
                    dvsr_d = neg_dvsr;
                end
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                rem_d = trial_ge ? trial : rem_sh;
                dvd_d = {dvd_q[WORDSIZE-2:0], trial_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WORDSIZE - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quot_d  = qneg_q ? neg_dvd : dvd_q;
                rmd_d   = rneg_q ? neg_rem : rem_q;
                dz_d    = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            signed_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dvd_q    <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            rmd_q    <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dvd_q    <= dvd_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            rmd_q    <= rmd_d;
            dz_q     <= dz_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: hand-computed results, latency, busy/done handshake, reset abort.

module tb_div_sequencer;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

    div_sequencer #(.WORDSIZE(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request, then watch edges until done (bounded). Optional extra
    // start pulses (85/3) are raised in cycles hit_a / hit_b.
    task automatic op(input logic s, input logic [63:0] a, input logic [63:0] b,
                      input int hit_a, input int hit_b,
                      output int lat, output bit busy_ok);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        lat       = 0;
        busy_ok   = 1'b1;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            start     = 1'b0;
            dividend  = {$urandom, $urandom};
            divisor   = {$urandom, $urandom};
            is_signed = 1'($urandom);
            if (lat == hit_a || lat == hit_b) begin
                start     = 1'b1;
                dividend  = 64'd85;
                divisor   = 64'd3;
                is_signed = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) break;
        end
    endtask

    task automatic run_check(input string tag, input logic s, input logic [63:0] a,
                             input logic [63:0] b, input int exp_lat,
                             input logic [63:0] exp_q, input logic [63:0] exp_r,
                             input logic exp_dz);
        int lat;
        bit bok;
        op(s, a, b, 0, 0, lat, bok);
        $display("[TB] %s: lat=%0d q=%h r=%h dz=%0b", tag, lat, quotient, remainder, div_zero);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_q"}, quotient, exp_q);
        chk({tag, "_r"}, remainder, exp_r);
        chk({tag, "_dz"}, {63'd0, div_zero}, {63'd0, exp_dz});
        chk({tag, "_busy"}, {63'd0, bok}, 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        int  lat;
        bit  bok;
        bit  saw_done;

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_q", quotient, 64'd0);
        chk("reset_r", remainder, 64'd0);
        chk("reset_dz", {63'd0, div_zero}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_check("udiv_100_7", 1'b0, 64'd100, 64'd7, 67, 64'd14, 64'd2, 1'b0);
        run_check("sdiv_m100_7", 1'b1, -64'sd100, 64'd7, 67,
                  64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_check("sdiv_100_m7", 1'b1, 64'd100, -64'sd7, 67,
                  64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0);
        run_check("sdiv_m100_m7", 1'b1, -64'sd100, -64'sd7, 67,
                  64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_check("udiv_big", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 67,
                  64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 1'b0);
        run_check("sdiv_min_1", 1'b1, 64'h8000_0000_0000_0000, 64'd1, 67,
                  64'h8000_0000_0000_0000, 64'd0, 1'b0);
        run_check("udiv_zero", 1'b0, 64'h1234, 64'd0, 1,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1);
        run_check("sdiv_zero", 1'b1, 64'h1234, 64'd0, 1,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1);
        run_check("sdiv_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
                  64'h8000_0000_0000_0000, 64'd0, 1'b0);
        run_check("udiv_ovf_ops", 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 67,
                  64'd0, 64'h8000_0000_0000_0000, 1'b0);

        // Extra starts at cycle 10 and in the done cycle must both be ignored.
        op(1'b0, 64'd1000, 64'd33, 10, 67, lat, bok);
        $display("[TB] hs_first: lat=%0d q=%h r=%h", lat, quotient, remainder);
        chk("hs_lat", 64'(lat), 64'd67);
        chk("hs_q", quotient, 64'd30);
        chk("hs_r", remainder, 64'd10);
        chk("hs_busy", {63'd0, bok}, 64'd1);
        @(posedge clk);
        #1;
        $display("[TB] hs_after_done: busy=%0b q=%h", busy, quotient);
        chk("hs_ignored_busy", {63'd0, busy}, 64'd0);
        chk("hs_ignored_q", quotient, 64'd30);
        // Start in the cycle after done is accepted.
        op(1'b0, 64'd85, 64'd3, 0, 0, lat, bok);
        $display("[TB] hs_second: lat=%0d q=%h r=%h", lat, quotient, remainder);
        chk("hs2_lat", 64'(lat), 64'd67);
        chk("hs2_q", quotient, 64'd28);
        chk("hs2_r", remainder, 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation aborts it silently.
        is_signed = 1'b0;
        dividend  = 64'd100;
        divisor   = 64'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] rst_mid: busy=%0b done=%0b q=%h r=%h", busy, done, quotient, remainder);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        chk("rst_mid_q", quotient, 64'd0);
        chk("rst_mid_r", remainder, 64'd0);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        $display("[TB] rst_no_done: saw_done=%0b", saw_done);
        chk("rst_no_done", {63'd0, saw_done}, 64'd0);
        run_check("after_rst", 1'b0, 64'd100, 64'd7, 67, 64'd14, 64'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
